mt_reg_file: RTL and testbench

//  Multi-thread register file: NUM_THREADS independent banks of NUM_REGS x DATA_WIDTH words.
//  Two async read ports (rs/rt), one sync write port, write-to-read bypass, r0 hardwired to zero.
//  A sweep FSM zeroes all banks after reset, and zeroes one bank on request (thread restart).

---
 rtl/mt_reg_file_pkg.sv | 25 ++
 rtl/mt_reg_file_rf_read_port.sv | 39 +++
 rtl/mt_reg_file.sv | 176 +++++++++++++++++
 tb/tb_mt_reg_file.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mt_reg_file_pkg.sv
// ----------------------------------------------------------------------------
// mt_reg_file_pkg
// Shared types and default sizing for the multi-thread register file.
//   RF_DATA_WIDTH / RF_NUM_REGS / RF_NUM_THREADS : default geometry
//   rf_state_t                                   : sweep FSM state encoding
//   rf_tid_w()                                   : thread-id width (min 1 bit)
// ----------------------------------------------------------------------------
package mt_reg_file_pkg;

   localparam int RF_DATA_WIDTH  = 32;
   localparam int RF_NUM_REGS    = 32;
   localparam int RF_NUM_THREADS = 2;

   typedef enum logic [1:0] {
      RF_INIT  = 2'd0,
      RF_IDLE  = 2'd1,
      RF_CLEAR = 2'd2
   } rf_state_t;

   // A single-thread build still carries a 1-bit thread id.
   function automatic int rf_tid_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mt_reg_file_rf_read_port.sv
// ----------------------------------------------------------------------------
// rf_read_port
// Output mux for one read port: forced zero, write-back bypass, or bank data.
//   i_en        : port enabled by decode
//   i_addr      : register index being read
//   i_zero      : read must return zero (INIT sweep or bank under clear)
//   i_wr_hit    : an accepted write targets the same thread this cycle
//   i_wr_addr   : register index of that write
//   i_wr_data   : data of that write
//   i_bank_data : stored word at {rd_tid, i_addr}
//   o_data      : combinational read result
// ----------------------------------------------------------------------------
module rf_read_port #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_W     = 5
) (
   input  logic                  i_en,
   input  logic [ADDR_W-1:0]     i_addr,
   input  logic                  i_zero,
   input  logic                  i_wr_hit,
   input  logic [ADDR_W-1:0]     i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic [DATA_WIDTH-1:0] i_bank_data,
   output logic [DATA_WIDTH-1:0] o_data
);

   // Priority: zero conditions, then same-cycle bypass, then storage.
   always_comb begin
      o_data = {DATA_WIDTH{1'b0}};
      if (!i_en || (i_addr == {ADDR_W{1'b0}}) || i_zero) begin
         o_data = {DATA_WIDTH{1'b0}};
      end else if (i_wr_hit && (i_wr_addr == i_addr)) begin
         o_data = i_wr_data;
      end else begin
         o_data = i_bank_data;
      end
   end

endmodule

// File: rtl/mt_reg_file.sv
// ----------------------------------------------------------------------------
// mt_reg_file
// Fine-grained multi-thread register file: NUM_THREADS banks of NUM_REGS words,
// two async read ports with write bypass, one sync write port, r0 reads zero.
// A sweep FSM zeroes every bank after reset and one bank on clear request.
//   i_clk, i_rst                 : clock, async active-high reset
//   i_rd_tid                     : thread for both read ports
//   i_uses_rs/i_rs_addr/o_rs_data: rs port
//   i_uses_rt/i_rt_addr/o_rt_data: rt port
//   i_wr_en/i_wr_tid/i_wr_addr/i_wr_data : write-back port
//   i_clr_req/i_clr_tid          : bank clear request (sampled in IDLE)
//   o_clr_ack                    : one-cycle pulse when the clear finished
//   o_ready                      : low while the post-reset sweep runs
// ----------------------------------------------------------------------------
module mt_reg_file
   import mt_reg_file_pkg::*;
#(
   parameter  int DATA_WIDTH  = RF_DATA_WIDTH,
   parameter  int NUM_REGS    = RF_NUM_REGS,
   parameter  int NUM_THREADS = RF_NUM_THREADS,
   localparam int ADDR_W      = $clog2(NUM_REGS),
   localparam int TID_W       = rf_tid_w(NUM_THREADS)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [TID_W-1:0]      i_rd_tid,
   input  logic                  i_uses_rs,
   input  logic [ADDR_W-1:0]     i_rs_addr,
   input  logic                  i_uses_rt,
   input  logic [ADDR_W-1:0]     i_rt_addr,
   output logic [DATA_WIDTH-1:0] o_rs_data,
   output logic [DATA_WIDTH-1:0] o_rt_data,
   input  logic                  i_wr_en,
   input  logic [TID_W-1:0]      i_wr_tid,
   input  logic [ADDR_W-1:0]     i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic                  i_clr_req,
   input  logic [TID_W-1:0]      i_clr_tid,
   output logic                  o_clr_ack,
   output logic                  o_ready
);

   localparam logic [ADDR_W-1:0] CNT_FIRST = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] CNT_LAST  = ADDR_W'(NUM_REGS - 1);

   rf_state_t              r_state;
   logic [ADDR_W-1:0]      r_cnt;
   logic [TID_W-1:0]       r_clr_tid;
   logic                   r_clr_ack;
   logic                   r_ready;

   // Storage is RAM-style and never reset; indexed by {tid, addr}.
   logic [DATA_WIDTH-1:0]  r_mem [NUM_THREADS*NUM_REGS];

   logic                   w_in_init;
   logic                   w_in_clear;
   logic                   w_rd_zero;
   logic                   w_wr_acc;
   logic                   w_wr_hit;
   logic [DATA_WIDTH-1:0]  w_rs_bank;
   logic [DATA_WIDTH-1:0]  w_rt_bank;

   assign w_in_init  = (r_state == RF_INIT);
   assign w_in_clear = (r_state == RF_CLEAR);

   // The bank under clear reads as zero and refuses writes; other banks run freely.
   assign w_rd_zero = w_in_init || (w_in_clear && (i_rd_tid == r_clr_tid));
   assign w_wr_acc  = !w_in_init && i_wr_en && (i_wr_addr != {ADDR_W{1'b0}}) &&
                      !(w_in_clear && (i_wr_tid == r_clr_tid));
   assign w_wr_hit  = w_wr_acc && (i_wr_tid == i_rd_tid);

   assign w_rs_bank = r_mem[{i_rd_tid, i_rs_addr}];
   assign w_rt_bank = r_mem[{i_rd_tid, i_rt_addr}];

   rf_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_W     (ADDR_W)
   ) u_rs_port (
      .i_en        (i_uses_rs),
      .i_addr      (i_rs_addr),
      .i_zero      (w_rd_zero),
      .i_wr_hit    (w_wr_hit),
      .i_wr_addr   (i_wr_addr),
      .i_wr_data   (i_wr_data),
      .i_bank_data (w_rs_bank),
      .o_data      (o_rs_data)
   );

   rf_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_W     (ADDR_W)
   ) u_rt_port (
      .i_en        (i_uses_rt),
      .i_addr      (i_rt_addr),
      .i_zero      (w_rd_zero),
      .i_wr_hit    (w_wr_hit),
      .i_wr_addr   (i_wr_addr),
      .i_wr_data   (i_wr_data),
      .i_bank_data (w_rt_bank),
      .o_data      (o_rt_data)
   );

   // Storage update: INIT zeroes index cnt in every bank; otherwise the accepted
   // write and the CLEAR sweep target different banks, so they never collide.
   always_ff @(posedge i_clk) begin
      if (w_in_init) begin
         for (int t = 0; t < NUM_THREADS; t++) begin
            r_mem[{TID_W'(t), r_cnt}] <= {DATA_WIDTH{1'b0}};
         end
      end else begin
         if (w_wr_acc) begin
            r_mem[{i_wr_tid, i_wr_addr}] <= i_wr_data;
         end
         if (w_in_clear) begin
            r_mem[{r_clr_tid, r_cnt}] <= {DATA_WIDTH{1'b0}};
         end
      end
   end

   // Sweep FSM with registered ready and clear-acknowledge outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= RF_INIT;
         r_cnt     <= CNT_FIRST;
         r_clr_tid <= {TID_W{1'b0}};
         r_clr_ack <= 1'b0;
         r_ready   <= 1'b0;
      end else begin
         case (r_state)
            RF_INIT: begin
               r_clr_ack <= 1'b0;
               if (r_cnt == CNT_LAST) begin
                  r_state <= RF_IDLE;
                  r_cnt   <= CNT_FIRST;
                  r_ready <= 1'b1;
               end else begin
                  r_cnt   <= r_cnt + CNT_FIRST;
                  r_ready <= 1'b0;
               end
            end
            RF_IDLE: begin
               r_clr_ack <= 1'b0;
               r_ready   <= 1'b1;
               if (i_clr_req) begin
                  r_state   <= RF_CLEAR;
                  r_clr_tid <= i_clr_tid;
                  r_cnt     <= CNT_FIRST;
               end else begin
                  r_state   <= RF_IDLE;
               end
            end
            RF_CLEAR: begin
               r_ready <= 1'b1;
               if (r_cnt == CNT_LAST) begin
                  r_state   <= RF_IDLE;
                  r_cnt     <= CNT_FIRST;
                  r_clr_ack <= 1'b1;
               end else begin
                  r_cnt     <= r_cnt + CNT_FIRST;
                  r_clr_ack <= 1'b0;
               end
            end
            default: begin
               r_state   <= RF_INIT;
               r_cnt     <= CNT_FIRST;
               r_clr_ack <= 1'b0;
               r_ready   <= 1'b0;
            end
         endcase
      end
   end

   assign o_clr_ack = r_clr_ack;
   assign o_ready   = r_ready;

endmodule

// File: tb/tb_mt_reg_file.sv
// ----------------------------------------------------------------------------
// tb_mt_reg_file
// Randomised and directed stimulus for mt_reg_file. Expected outputs come from
// a behavioural model (per-thread arrays plus "busy for N cycles" bookkeeping)
// and are queued; a monitor pops and compares them each cycle.
// ----------------------------------------------------------------------------
module tb_mt_reg_file;

   localparam int DW    = 32;
   localparam int NREG  = 32;
   localparam int NTHR  = 2;
   localparam int SWEEP = NREG - 1;

   logic          clk;
   logic          rst;
   logic          rd_tid;
   logic          uses_rs;
   logic [4:0]    rs_addr;
   logic          uses_rt;
   logic [4:0]    rt_addr;
   logic [DW-1:0] rs_data;
   logic [DW-1:0] rt_data;
   logic          wr_en;
   logic          wr_tid;
   logic [4:0]    wr_addr;
   logic [DW-1:0] wr_data;
   logic          clr_req;
   logic          clr_tid;
   logic          clr_ack;
   logic          ready;

   mt_reg_file #(
      .DATA_WIDTH  (DW),
      .NUM_REGS    (NREG),
      .NUM_THREADS (NTHR)
   ) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_rd_tid  (rd_tid),
      .i_uses_rs (uses_rs),
      .i_rs_addr (rs_addr),
      .i_uses_rt (uses_rt),
      .i_rt_addr (rt_addr),
      .o_rs_data (rs_data),
      .o_rt_data (rt_data),
      .i_wr_en   (wr_en),
      .i_wr_tid  (wr_tid),
      .i_wr_addr (wr_addr),
      .i_wr_data (wr_data),
      .i_clr_req (clr_req),
      .i_clr_tid (clr_tid),
      .o_clr_ack (clr_ack),
      .o_ready   (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] rs;
      logic [DW-1:0] rt;
      logic          rdy;
      logic          ack;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   int   ack_seen = 0;

   // Reference model: register contents and a "busy" phase described by how
   // many cycles remain, not by a sweep pointer.
   logic [DW-1:0] m_mem [NTHR][NREG];
   int            m_phase;     // 0 = sweeping after reset, 1 = normal, 2 = bank clear
   int            m_left;
   int            m_bank;
   logic          m_ack;

   task automatic model_reset();
      for (int t = 0; t < NTHR; t++)
         for (int r = 0; r < NREG; r++)
            m_mem[t][r] = '0;
      m_phase = 0;
      m_left  = SWEEP;
      m_bank  = 0;
      m_ack   = 1'b0;
   endtask

   function automatic logic [DW-1:0] model_read(input logic u, input logic [4:0] a,
                                                input logic acc);
      if (!u || a == 5'd0 || m_phase == 0 || (m_phase == 2 && int'(rd_tid) == m_bank))
         return '0;
      if (acc && wr_tid == rd_tid && wr_addr == a)
         return wr_data;
      return m_mem[rd_tid][a];
   endfunction

   task automatic cyc(input logic r, input logic rt_id, input logic urs, input logic [4:0] rsa,
                      input logic urt, input logic [4:0] rta, input logic we, input logic wt,
                      input logic [4:0] wa, input logic [DW-1:0] wd, input logic cr,
                      input logic ct);
      exp_t e;
      logic acc;
      @(negedge clk);
      rst = r; rd_tid = rt_id; uses_rs = urs; rs_addr = rsa; uses_rt = urt; rt_addr = rta;
      wr_en = we; wr_tid = wt; wr_addr = wa; wr_data = wd; clr_req = cr; clr_tid = ct;
      if (r) model_reset();
      acc = (m_phase != 0) && we && (wa != 5'd0) && !(m_phase == 2 && int'(wt) == m_bank);
      e.rs  = model_read(urs, rsa, acc);
      e.rt  = model_read(urt, rta, acc);
      e.rdy = (m_phase != 0);
      e.ack = m_ack;
      q.push_back(e);
      @(posedge clk);
      if (!r) begin
         if (acc) m_mem[wt][wa] = wd;
         m_ack = 1'b0;
         case (m_phase)
            0: begin
               m_left--;
               if (m_left == 0) m_phase = 1;
            end
            1: begin
               if (cr) begin
                  m_phase = 2;
                  m_bank  = int'(ct);
                  m_left  = SWEEP;
               end
            end
            2: begin
               m_left--;
               if (m_left == 0) begin
                  m_phase = 1;
                  for (int i = 0; i < NREG; i++) m_mem[m_bank][i] = '0;
                  m_ack = 1'b1;
               end
            end
            default: m_phase = 0;
         endcase
      end
   endtask

   task automatic idle_read(input logic t, input logic [4:0] a, input logic t2,
                            input logic [4:0] a2, input logic cr);
      cyc(1'b0, t, 1'b1, a, 1'b1, a2, 1'b0, t2, 5'd0, '0, cr, 1'b0);
   endtask

   task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   // Monitor: outputs are settled 2 time units after the stimulus edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (clr_ack) ack_seen++;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("rs_data", rs_data, e.rs);
            check("rt_data", rt_data, e.rt);
            check("ready", {31'd0, ready}, {31'd0, e.rdy});
            check("clr_ack", {31'd0, clr_ack}, {31'd0, e.ack});
         end
      end
   end

   initial begin
      int a0;
      rst = 1'b1; rd_tid = 1'b0; uses_rs = 1'b0; rs_addr = 5'd0; uses_rt = 1'b0;
      rt_addr = 5'd0; wr_en = 1'b0; wr_tid = 1'b0; wr_addr = 5'd0; wr_data = '0;
      clr_req = 1'b0; clr_tid = 1'b0;
      model_reset();

      // Reset, then the post-reset sweep with writes that must be dropped.
      repeat (3) cyc(1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 5'd3, 32'h1, 1'b0, 1'b0);
      for (int i = 0; i < 34; i++)
         cyc(1'b0, 1'($urandom), 1'b1, 5'($urandom), 1'b1, 5'($urandom),
             1'b1, 1'($urandom), 5'($urandom), $urandom, 1'b0, 1'b0);

      // Bypass then bank isolation.
      cyc(1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0);
      idle_read(1'b0, 5'd5, 1'b0, 5'd0, 1'b0);
      idle_read(1'b1, 5'd5, 1'b1, 5'd5, 1'b0);

      // r0 is hardwired; disabled rt port reads zero.
      cyc(1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 32'h1234, 1'b0, 1'b0);
      idle_read(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);

      // Clear bank 0 while bank 1 keeps working.
      cyc(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd7, 32'hA5A5A5A5, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b1, 1'b1, 5'd7, 32'h11, 1'b0, 1'b0);
      a0 = ack_seen;
      cyc(1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 31; i++) begin
         if (i == 4)
            cyc(1'b0, 1'b1, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b1, 5'd8, 32'h22, 1'b0, 1'b0);
         else if (i[0])
            cyc(1'b0, 1'b0, 1'b1, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0, 5'd9, $urandom, 1'b0, 1'b0);
         else
            idle_read(1'b1, 5'd7, 1'b1, 5'd8, 1'b0);
      end
      idle_read(1'b0, 5'd7, 1'b0, 5'd9, 1'b0);
      idle_read(1'b1, 5'd7, 1'b1, 5'd8, 1'b0);
      check("single_clear_acks", 32'(ack_seen - a0), 32'd1);

      // Held request: one ack per sweep, back-to-back sweeps.
      a0 = ack_seen;
      for (int i = 0; i < 70; i++)
         cyc(1'b0, 1'b0, 1'b1, 5'($urandom_range(1, 3)), 1'b1, 5'd7, 1'b0, 1'b0, 5'd0, '0,
             1'b1, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, '0, 1'b0, 1'b0);
      check("held_req_acks", 32'(ack_seen - a0), 32'd2);

      // Finish the sweep in progress, then reset in the middle of a clear.
      for (int i = 0; i < 35; i++) idle_read(1'b1, 5'd8, 1'b0, 5'd7, 1'b0);
      a0 = ack_seen;
      cyc(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, '0, 1'b1, 1'b1);
      for (int i = 0; i < 10; i++) idle_read(1'b1, 5'd8, 1'b0, 5'd7, 1'b0);
      repeat (2) cyc(1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 5'd8, 1'b0, 1'b0, 5'd0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) idle_read(1'b1, 5'd8, 1'b0, 5'd7, 1'b0);
      check("reset_mid_clear_acks", 32'(ack_seen - a0), 32'd0);

      // Random traffic with occasional clears and resets.
      for (int i = 0; i < 800; i++) begin
         logic [4:0] ra, rb, wa;
         ra = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         rb = 5'($urandom_range(0, 7));
         wa = 5'($urandom_range(0, 7));
         cyc(($urandom_range(0, 299) == 0), 1'($urandom), 1'($urandom_range(0, 7) != 0), ra,
             1'($urandom_range(0, 7) != 0), rb, 1'($urandom), 1'($urandom), wa, $urandom,
             ($urandom_range(0, 39) == 0), 1'($urandom));
      end

      @(negedge clk);
      #3;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL queue_drain got=%0d expected=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
